// File: rtl/spram_dma_pkg.sv
// spram_dma_pkg: state encoding and mode constants shared by the spram_dma engine
package spram_dma_pkg;
    typedef enum logic [2:0] {IDLE, FILL, COPY_RD, COPY_WR, DONE} state_e;
    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;
endpackage

// File: rtl/spram_dma.sv
// spram_dma: FILL/COPY engine for a single-port sync RAM; SPRAM_DMA_CHECKSUM_EN adds a write checksum
module spram_dma
    import spram_dma_pkg::*;
#(
    parameter int address_width = 10,
    parameter int data_width = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [address_width-1:0] src_addr,
    input  logic [address_width-1:0] dst_addr,
    input  logic [address_width:0]   length,
    input  logic [data_width-1:0]    fill_value,
    output logic                     busy,
    output logic                     done,
    output logic [address_width-1:0] ram_address,
    output logic                     ram_wren,
    output logic [data_width-1:0]    ram_data,
    input  logic [data_width-1:0]    ram_q
`ifdef SPRAM_DMA_CHECKSUM_EN
    ,
    output logic [data_width-1:0]    checksum
`endif
);
    localparam logic [address_width:0] full_len = {1'b1, {address_width{1'b0}}};
    state_e state_q, state_d;
    logic [address_width-1:0] src_q, src_d, dst_q, dst_d, ram_address_q, ram_address_d;
    logic [address_width:0] rem_q, rem_d, len_c;
    logic [data_width-1:0] ram_data_q, ram_data_d;
    logic ram_wren_q, ram_wren_d, busy_q, busy_d, done_q, done_d;
    assign len_c = length > full_len ? full_len : length;
    // rem holds the words still to go after the one in flight
    always_comb begin
        state_d = state_q;
        src_d = src_q;
        dst_d = dst_q;
        rem_d = rem_q;
        ram_address_d = ram_address_q;
        ram_data_d = ram_data_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = length == '0 ? DONE : mode == MODE_COPY ? COPY_RD : FILL;
                rem_d = len_c - 1'b1;
                ram_data_d = fill_value;
                ram_address_d = mode == MODE_FILL ? dst_addr : src_addr;
                src_d = mode == MODE_COPY ? src_addr + 1'b1 : src_addr;
                dst_d = mode == MODE_FILL ? dst_addr + 1'b1 : dst_addr;
            end
            FILL: if (rem_q == '0) state_d = DONE;
                else begin
                    ram_address_d = dst_q;
                    dst_d = dst_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end
            COPY_RD: begin
                state_d = COPY_WR;
                ram_address_d = dst_q;
                dst_d = dst_q + 1'b1;
            end
            COPY_WR: if (rem_q == '0) state_d = DONE;
                else begin
                    state_d = COPY_RD;
                    ram_address_d = src_q;
                    src_d = src_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                end
            default: state_d = IDLE;
        endcase
        ram_wren_d = state_d == FILL || state_d == COPY_WR;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            ram_address_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            ram_address_q <= ram_address_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign ram_address = ram_address_q;
    assign ram_wren = ram_wren_q;
    // q is the RAM's own output register, so copy writes forward it straight through
    assign ram_data = state_q == COPY_WR ? ram_q : ram_data_q;
`ifdef SPRAM_DMA_CHECKSUM_EN
    logic [data_width-1:0] checksum_q, checksum_d;
    assign checksum_d = state_q == IDLE && start ? '0
                      : state_q == FILL || state_q == COPY_WR ? checksum_q + ram_data
                      : checksum_q;
    always_ff @(posedge clock) begin
        if (reset) checksum_q <= '0;
        else checksum_q <= checksum_d;
    end
    assign checksum = checksum_q;
`endif
endmodule
